// File: rtl/ibus_model_pkg.sv
// Shared types, constants and helpers for the MR1 instruction-bus slave model.
// The queue entry and the range check are used by both the top and the pending FIFO.
package ibus_model_pkg;

  // Wait counters are sized for the largest legal fairness bound (7) so every
  // MAX_WAIT setting fits in the same entry layout.
  localparam int MAX_WAIT_LIMIT = 7;
  localparam int WAIT_W         = $clog2(MAX_WAIT_LIMIT + 1);

  localparam logic [31:0] RSP_ERR_INST = 32'h0;

  typedef struct packed {
    logic [31:0]       pc;
    logic [WAIT_W-1:0] age;
  } ibus_entry_t;

  // A fetch hits the ROM only when word aligned and inside the 2^aw-word window.
  function automatic logic rom_in_range(input logic [31:0] pc, input int aw);
    logic [31:0] upper;
    upper = pc >> (aw + 2);
    return (pc[1:0] == 2'b00) && (upper == 32'h0);
  endfunction

endpackage

// File: rtl/ibus_pending_fifo.sv
// In-order queue of accepted fetch PCs awaiting a response.
// Only the head entry ages; every pushed entry starts with age zero.
module ibus_pending_fifo
  import ibus_model_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] pushPc,
  input  logic        pop,
  input  logic        ageHead,
  output ibus_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WAIT_W-1:0] AGE_MAX = WAIT_W'(MAX_WAIT);

  ibus_entry_t     entries [DEPTH];
  logic [PW-1:0]   wrPtrReg;
  logic [PW-1:0]   rdPtrReg;
  logic [CW-1:0]   countReg;
  logic            doPush;
  logic            doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full   = (countReg == CW'(DEPTH));
  assign empty  = (countReg == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = entries[rdPtrReg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) begin
        wrPtrReg <= nextPtr(wrPtrReg);
      end
      if (doPop) begin
        rdPtrReg <= nextPtr(rdPtrReg);
      end
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Storage needs no reset: an empty queue never exposes stale slots.
  // A push can never land on the head slot while it is ageing, since that
  // would require the queue to be either empty or full.
  always_ff @(posedge clock) begin
    if (doPush) begin
      entries[wrPtrReg] <= '{pc: pushPc, age: '0};
    end
    if (ageHead && !doPop && !empty && (entries[rdPtrReg].age != AGE_MAX)) begin
      entries[rdPtrReg].age <= entries[rdPtrReg].age + 1'b1;
    end
  end

endmodule

// File: rtl/ibus_fetch_responder.sv
// Instruction-bus slave model for the MR1 fetch port: queues fetch commands and
// answers them in order from a programmable ROM with bounded, stall-driven latency.
module ibus_fetch_responder
  import ibus_model_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int ROM_AW   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iBus_cmd_valid,
  output logic              iBus_cmd_ready,
  input  logic [31:0]       iBus_cmd_payload_pc,
  output logic              iBus_rsp_ready,
  output logic [31:0]       iBus_rsp_inst,
  output logic              iBus_rsp_error,
  input  logic              cmd_stall,
  input  logic              rsp_stall,
  input  logic              prog_we,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [31:0]       prog_data
);

  localparam int ROM_WORDS = 1 << ROM_AW;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [31:0]       rom [ROM_WORDS];

  logic              readyEnReg;
  logic [WAIT_W-1:0] cmdWaitReg;
  logic [WAIT_W-1:0] cmdWaitNext;
  logic              rspReadyReg;
  logic [31:0]       rspInstReg;
  logic              rspErrorReg;

  ibus_entry_t       head;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              cmdAccept;
  logic              rspFire;
  logic              ageHead;
  logic              headInRange;
  logic [ROM_AW-1:0] romIndex;

  // Ready depends only on registered state, so a pop in the same cycle cannot
  // open a slot for a push; readyEnReg keeps ready low until the first edge
  // after reset releases.
  assign iBus_cmd_ready = readyEnReg && !fifoFull && (!cmd_stall || (cmdWaitReg == WAIT_MAX));
  assign cmdAccept      = iBus_cmd_valid && iBus_cmd_ready;

  assign rspFire     = !fifoEmpty && (!rsp_stall || (head.age == WAIT_MAX));
  assign ageHead     = !fifoEmpty && !rspFire;
  assign headInRange = rom_in_range(head.pc, ROM_AW);
  assign romIndex    = head.pc[ROM_AW+1:2];

  ibus_pending_fifo #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) pendingFifo (
    .clock   (clock),
    .reset   (reset),
    .push    (cmdAccept),
    .pushPc  (iBus_cmd_payload_pc),
    .pop     (rspFire),
    .ageHead (ageHead),
    .head    (head),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_comb begin
    cmdWaitNext = '0;
    if (iBus_cmd_valid && !iBus_cmd_ready) begin
      cmdWaitNext = (cmdWaitReg == WAIT_MAX) ? cmdWaitReg : cmdWaitReg + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readyEnReg <= 1'b0;
      cmdWaitReg <= '0;
    end else begin
      readyEnReg <= 1'b1;
      cmdWaitReg <= cmdWaitNext;
    end
  end

  // The ROM is read when the response is registered, so a write to the same
  // word on this edge is seen only by later fetches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rspReadyReg <= 1'b0;
      rspInstReg  <= '0;
      rspErrorReg <= 1'b0;
    end else begin
      rspReadyReg <= rspFire;
      if (rspFire) begin
        rspInstReg  <= headInRange ? rom[romIndex] : RSP_ERR_INST;
        rspErrorReg <= !headInRange;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (prog_we) begin
      rom[prog_addr] <= prog_data;
    end
  end

  assign iBus_rsp_ready = rspReadyReg;
  assign iBus_rsp_inst  = rspInstReg;
  assign iBus_rsp_error = rspErrorReg;

endmodule

// File: tb/tb_ibus_fetch_responder.sv
// Bench for ibus_fetch_responder: fixed vectors, hand-written corner sequences and
// a randomized run, all checked against a queue-based reference model.
module tb_ibus_fetch_responder;

  localparam int DEPTH    = 2;
  localparam int ROM_AW   = 8;
  localparam int MAX_WAIT = 3;

  localparam logic [31:0] W_I0 = 32'h0000_0013;
  localparam logic [31:0] W_A  = 32'hA0A0_0001;
  localparam logic [31:0] W_B  = 32'hB0B0_0002;
  localparam logic [31:0] W_C  = 32'hC0C0_0003;
  localparam logic [31:0] W_D  = 32'hD0D0_0004;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iBus_cmd_valid = 1'b0;
  logic        iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc = '0;
  logic        iBus_rsp_ready;
  logic [31:0] iBus_rsp_inst;
  logic        iBus_rsp_error;
  logic        cmd_stall = 1'b0;
  logic        rsp_stall = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;

  ibus_fetch_responder #(
    .DEPTH    (DEPTH),
    .ROM_AW   (ROM_AW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iBus_cmd_valid      (iBus_cmd_valid),
    .iBus_cmd_ready      (iBus_cmd_ready),
    .iBus_cmd_payload_pc (iBus_cmd_payload_pc),
    .iBus_rsp_ready      (iBus_rsp_ready),
    .iBus_rsp_inst       (iBus_rsp_inst),
    .iBus_rsp_error      (iBus_rsp_error),
    .cmd_stall           (cmd_stall),
    .rsp_stall           (rsp_stall),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_data           (prog_data)
  );

  initial forever #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;

  // Reference model: pending PCs as a plain queue plus the two wait counts.
  int unsigned pcQ[$];
  int          cmdWaitM;
  int          headAgeM;
  logic [31:0] romM [256];
  bit          aliveM;
  bit          expRsp;
  logic [31:0] expInst;
  bit          expErr;
  bit          seenReady;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          we;
    logic [7:0]  pa;
    logic [31:0] pd;
    bit          eReady;
    bit          eRsp;
    logic [31:0] eInst;
    bit          eErr;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input bit v, input logic [31:0] p, input bit we,
                              input logic [7:0] pa, input logic [31:0] pd,
                              input bit er, input bit ersp, input logic [31:0] ei,
                              input bit ee);
    vec_t t;
    t.valid = v; t.pc = p; t.we = we; t.pa = pa; t.pd = pd;
    t.eReady = er; t.eRsp = ersp; t.eInst = ei; t.eErr = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    pcQ.delete();
    cmdWaitM = 0;
    headAgeM = 0;
    aliveM   = 1'b0;
    expRsp   = 1'b0;
    expInst  = '0;
    expErr   = 1'b0;
  endtask

  task automatic setIn(input bit v, input logic [31:0] p, input bit cs, input bit rs);
    iBus_cmd_valid      = v;
    iBus_cmd_payload_pc = p;
    cmd_stall           = cs;
    rsp_stall           = rs;
    prog_we             = 1'b0;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic doCycle();
    bit          expReady;
    bit          accept;
    bit          fire;
    int unsigned pc;
    #3;
    expReady  = aliveM && (pcQ.size() < DEPTH) && (!cmd_stall || cmdWaitM == MAX_WAIT);
    seenReady = iBus_cmd_ready;
    chk("cmd_ready", 32'(iBus_cmd_ready), 32'(expReady));
    accept = iBus_cmd_valid && expReady;
    fire   = (pcQ.size() > 0) && (!rsp_stall || headAgeM == MAX_WAIT);
    if (fire) begin
      pc     = pcQ.pop_front();
      expRsp = 1'b1;
      if ((pc % 4 == 0) && (pc < (4 << ROM_AW))) begin
        expInst = romM[pc / 4];
        expErr  = 1'b0;
      end else begin
        expInst = '0;
        expErr  = 1'b1;
      end
      headAgeM = 0;
    end else begin
      expRsp = 1'b0;
      if (pcQ.size() > 0 && headAgeM < MAX_WAIT) headAgeM++;
    end
    if (accept) begin
      pcQ.push_back(iBus_cmd_payload_pc);
      cmdWaitM = 0;
    end else if (iBus_cmd_valid) begin
      cmdWaitM = (cmdWaitM < MAX_WAIT) ? cmdWaitM + 1 : MAX_WAIT;
    end else begin
      cmdWaitM = 0;
    end
    if (prog_we) romM[prog_addr] = prog_data;
    aliveM = 1'b1;
    @(posedge clock);
    #1;
    chk("rsp_ready", 32'(iBus_rsp_ready), 32'(expRsp));
    chk("rsp_inst", iBus_rsp_inst, expInst);
    chk("rsp_error", 32'(iBus_rsp_error), 32'(expErr));
    if (expRsp) $display("rsp inst=%h err=%0d pending=%0d", expInst, expErr, pcQ.size());
  endtask

  initial begin
    bit          v;
    bit          cs;
    bit          rs;
    int          sel;
    logic [31:0] p;

    resetModel();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_cmd_ready", 32'(iBus_cmd_ready), 32'h0);
    chk("reset_rsp_ready", 32'(iBus_rsp_ready), 32'h0);
    chk("reset_rsp_inst", iBus_rsp_inst, 32'h0);
    chk("reset_rsp_error", 32'(iBus_rsp_error), 32'h0);
    reset = 1'b0;

    // Fill the whole ROM so every later fetch reads defined data.
    for (int a = 0; a < 256; a++) begin
      setIn(1'b0, '0, 1'b0, 1'b0);
      prog_we   = 1'b1;
      prog_addr = 8'(a);
      prog_data = $urandom;
      doCycle();
    end
    prog_we = 1'b0;

    tbl[0]  = mk(0, 32'h0,   1, 8'd0, W_I0, 1, 0, 32'h0, 0);
    tbl[1]  = mk(1, 32'h0,   0, 8'd0, 32'h0, 1, 0, 32'h0, 0);
    tbl[2]  = mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 1, W_I0, 0);
    tbl[3]  = mk(0, 32'h0,   1, 8'd0, W_A,  1, 0, W_I0, 0);
    tbl[4]  = mk(0, 32'h0,   1, 8'd1, W_B,  1, 0, W_I0, 0);
    tbl[5]  = mk(0, 32'h0,   1, 8'd2, W_C,  1, 0, W_I0, 0);
    tbl[6]  = mk(1, 32'h0,   0, 8'd0, 32'h0, 1, 0, W_I0, 0);
    tbl[7]  = mk(1, 32'h4,   0, 8'd0, 32'h0, 1, 1, W_A, 0);
    tbl[8]  = mk(1, 32'h8,   0, 8'd0, 32'h0, 1, 1, W_B, 0);
    tbl[9]  = mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 1, W_C, 0);
    tbl[10] = mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 0, W_C, 0);
    tbl[11] = mk(1, 32'h2,   0, 8'd0, 32'h0, 1, 0, W_C, 0);
    tbl[12] = mk(1, 32'h400, 0, 8'd0, 32'h0, 1, 1, 32'h0, 1);
    tbl[13] = mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 1, 32'h0, 1);
    tbl[14] = mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 0, 32'h0, 1);
    tbl[15] = mk(1, 32'h4,   0, 8'd0, 32'h0, 1, 0, 32'h0, 1);
    tbl[16] = mk(0, 32'h0,   1, 8'd1, W_D,  1, 1, W_B, 0);
    tbl[17] = mk(1, 32'h4,   0, 8'd0, 32'h0, 1, 0, W_B, 0);
    tbl[18] = mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 1, W_D, 0);

    foreach (tbl[i]) begin
      setIn(tbl[i].valid, tbl[i].pc, 1'b0, 1'b0);
      prog_we   = tbl[i].we;
      prog_addr = tbl[i].pa;
      prog_data = tbl[i].pd;
      doCycle();
      $display("vec %0d valid=%0d pc=%h we=%0d", i, tbl[i].valid, tbl[i].pc, tbl[i].we);
      chk($sformatf("vec%0d_ready", i), 32'(seenReady), 32'(tbl[i].eReady));
      chk($sformatf("vec%0d_rsp", i), 32'(iBus_rsp_ready), 32'(tbl[i].eRsp));
      chk($sformatf("vec%0d_inst", i), iBus_rsp_inst, tbl[i].eInst);
      chk($sformatf("vec%0d_err", i), 32'(iBus_rsp_error), 32'(tbl[i].eErr));
    end

    // Forced accept: ready withheld for MAX_WAIT cycles, then granted.
    setIn(1'b1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i <= MAX_WAIT; i++) begin
      doCycle();
      chk($sformatf("fa_ready%0d", i), 32'(seenReady), 32'(i == MAX_WAIT));
    end
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    doCycle();
    chk("fa_rsp", 32'(iBus_rsp_ready), 32'h1);
    chk("fa_inst", iBus_rsp_inst, W_A);

    // Forced response: rsp_stall held, response released once the head hits MAX_WAIT.
    setIn(1'b1, 32'h8, 1'b0, 1'b1);
    doCycle();
    setIn(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i <= MAX_WAIT; i++) begin
      doCycle();
      chk($sformatf("fr_rsp%0d", i), 32'(iBus_rsp_ready), 32'(i == MAX_WAIT));
    end
    chk("fr_inst", iBus_rsp_inst, W_C);

    // Full queue: ready stays low through the popping cycle, returns after it.
    setIn(1'b1, 32'h0, 1'b0, 1'b1);
    doCycle();
    setIn(1'b1, 32'h4, 1'b0, 1'b1);
    doCycle();
    setIn(1'b1, 32'h8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      doCycle();
      chk($sformatf("full_ready%0d", i), 32'(seenReady), 32'h0);
    end
    chk("full_pop_rsp", 32'(iBus_rsp_ready), 32'h1);
    chk("full_pop_inst", iBus_rsp_inst, W_A);
    setIn(1'b1, 32'h8, 1'b0, 1'b0);
    doCycle();
    chk("full_ready_back", 32'(seenReady), 32'h1);
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) doCycle();

    // Reset with two commands pending: outputs clear at once, nothing answers later.
    setIn(1'b1, 32'h0, 1'b0, 1'b1);
    doCycle();
    setIn(1'b1, 32'h4, 1'b0, 1'b1);
    doCycle();
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(iBus_cmd_ready), 32'h0);
    chk("rst_rsp_ready", 32'(iBus_rsp_ready), 32'h0);
    chk("rst_rsp_inst", iBus_rsp_inst, 32'h0);
    chk("rst_rsp_error", 32'(iBus_rsp_error), 32'h0);
    resetModel();
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("rst_hold_rsp", 32'(iBus_rsp_ready), 32'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      doCycle();
      chk($sformatf("post_rst_rsp%0d", i), 32'(iBus_rsp_ready), 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 99) < 65);
      cs  = ($urandom_range(0, 1) == 1);
      rs  = ($urandom_range(0, 1) == 1);
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       p = $urandom_range(0, 255) * 4;
      else if (sel == 7) p = $urandom_range(0, 1023);
      else if (sel == 8) p = 32'h400 + $urandom_range(0, 255) * 4;
      else               p = $urandom;
      setIn(v, p, cs, rs);
      prog_we   = ($urandom_range(0, 9) == 0);
      prog_addr = 8'($urandom_range(0, 255));
      prog_data = $urandom;
      doCycle();
    end
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) doCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_fetch_responder.md
Name: ibus_fetch_responder

Overview:
- Instruction-bus slave model that drives the MR1 iBus in formal and simulation harnesses. It sits directly upstream of the core's fetch port.
- It accepts fetch commands over a valid/ready handshake and queues their PCs in order. It returns one instruction word per command from a small programmable ROM.
- Response latency is variable, controlled by stall inputs that formal can drive freely. A built-in fairness bound caps every wait at MAX_WAIT cycles, so the harness needs no external restrict counters.

Parameters:
- DEPTH, 2, maximum outstanding (accepted but not yet responded) commands; power of two, ≥1.
- ROM_AW, 8, ROM address width in words (ROM size 2^ROM_AW × 32).
- MAX_WAIT, 3, maximum consecutive stalled cycles before progress is forced; 1..7.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- iBus_cmd_valid  in  1  core requests a fetch.
- iBus_cmd_ready  out  1  command accepted when valid && ready.
- iBus_cmd_payload_pc  in  32  fetch byte address.
- iBus_rsp_ready  out  1  response valid, one-cycle pulse per response; the core cannot stall it.
- iBus_rsp_inst  out  32  instruction word.
- iBus_rsp_error  out  1  fetch fault flag, qualified by iBus_rsp_ready.
- cmd_stall  in  1  requests withholding iBus_cmd_ready this cycle.
- rsp_stall  in  1  requests withholding the response this cycle.
- prog_we  in  1  ROM write strobe.
- prog_addr  in  ROM_AW  ROM word address.
- prog_data  in  32  ROM write data.

Behaviour:
- Reset (async, active-high): queue empty, count=0, all wait counters 0, iBus_cmd_ready=0, iBus_rsp_ready=0, iBus_rsp_inst=0, iBus_rsp_error=0. ROM contents are not reset.
- Queue: circular FIFO of DEPTH entries. Each entry holds pc[31:0] and an age counter of width clog2(MAX_WAIT+1). Read and write pointers wrap modulo DEPTH.
- cmd_wait counter:
  - Increments while iBus_cmd_valid && !iBus_cmd_ready.
  - Clears on accept or when valid is low.
  - Saturates at MAX_WAIT.
- iBus_cmd_ready is combinational from registered state only:
  - ready = (count < DEPTH) && (!cmd_stall || cmd_wait == MAX_WAIT).
  - There is no combinational path from pop to ready. When full, a same-cycle pop does not enable a push.
- Accept (valid && ready): push pc at the write pointer with age 0. The entry becomes response-eligible the next cycle, so minimum latency is 1 cycle (accept at edge N, earliest rsp at edge N+1).
- Response:
  - Fires when count > 0 && (!rsp_stall || head.age == MAX_WAIT).
  - Firing registers iBus_rsp_ready=1 for exactly one cycle, sets inst/error from the head entry, and pops the head.
  - When not firing, iBus_rsp_ready=0. iBus_rsp_inst/error hold their last value.
  - Age: the head's age increments each cycle it is eligible but not fired, saturating at MAX_WAIT. Non-head ages stay 0.
- Ordering: responses are strictly in acceptance order, one per accepted command. The queue never drops or duplicates an entry.
- Data:
  - If pc[1:0] != 0 or pc[31:ROM_AW+2] != 0: error=1, inst=0.
  - Otherwise: error=0, inst=rom[pc[ROM_AW+1:2]].
  - ROM is read at response time, not at accept time.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Programming:
  - prog_we writes the ROM on the clock edge.
  - A write to the address being responded in the same cycle returns the old data (read-before-write).
- Reset mid-operation clears the queue immediately. Outstanding commands receive no response, and no output pulses after reset asserts.
- Fairness guarantee:
  - A valid command waits at most MAX_WAIT cycles for ready while the queue is not full.
  - Each response arrives at most MAX_WAIT+1 cycles after its entry reaches the head.

Decomposition:
- Package ibus_model_pkg:
  - ibus_entry_t struct {pc, age}.
  - Constants RSP_ERR_INST=32'h0, WAIT_W derived from MAX_WAIT.
  - Function rom_in_range(pc, aw).
- One sub-module, ibus_pending_fifo: the parameterized in-order queue with push/pop/count/full/empty and head access. The ROM, stall/fairness logic and response register stay in the top.

Test Plan:
- Basic fetch: ROM[0]=32'h00000013, stalls low; cmd pc=0 accepted at cycle 0 → rsp_ready=1 at cycle 1 with inst=32'h00000013, error=0.
- Back-to-back: pc=0,4,8 issued on consecutive cycles, ROM[0..2]=A,B,C, stalls low → inst A,B,C in order on consecutive cycles; ready stays 1 throughout (count never reaches DEPTH=2).
- Forced response progress: one pending entry, rsp_stall held 1 → no response for 3 cycles, then rsp_ready=1 on the 4th eligible cycle (age==MAX_WAIT=3).
- Forced accept progress: cmd_stall held 1, valid held 1, queue empty → ready=0 for 3 cycles, then ready=1 and accept on the 4th.
- Full queue: rsp_stall=1, two commands accepted → ready=0 while count=2; the same-cycle pop does not raise ready; ready returns the cycle after the pop.
- Errors and reset: pc=32'h2 → error=1, inst=0; pc=32'h400 (out of range for ROM_AW=8) → error=1. Assert reset with 2 pending → outputs 0 immediately, and no rsp pulses after reset deasserts.
